nes_controller_responder: RTL and testbench
===========================================

Name: nes_controller_responder

Overview:
- Controller-side end of the NES serial pad protocol: a 4021-style parallel-in/serial-out shift register driven by a host's latch/clock lines.
- Parallel button states from board switches or the bench are sampled on latch; bits are shifted out active-low on each host clock rising edge.
- Used as an on-board pad emulator and as the bench-side stimulus for the game's NES receiver path (NES_Latch / NES_Clk / NES_Data).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on nes_latch and nes_clk (minimum 2).
- FILL_BIT, 0, level driven on nes_data after 8 bits have been shifted (0 matches an official pad).
- TURBO_LOG2, 2, turbo toggle period exponent in latch events (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- buttons  input  8  active-high {Right,Left,Down,Up,Start,Select,B,A}; bit0 = A is shifted first
- nes_latch  input  1  host latch, asynchronous to clk
- nes_clk  input  1  host shift clock, asynchronous to clk
- nes_data  output  1  serial data, active-low (0 = pressed), registered
- bit_count  output  4  number of bits shifted since last latch, 0..8, saturating
- frame_done  output  1  one-cycle pulse when the 8th bit is shifted
- turbo_en  input  2  {B,A} turbo enables; present only with NES_TURBO_EN

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - shift_reg = 8'hFF; nes_data = 1; bit_count = 0; frame_done = 0.
  - All synchroniser and edge-detect flops = 0; turbo counter = 0.
- Synchronisation:
  - nes_latch and nes_clk each pass through SYNC_STAGES flops, giving lat_s and clk_s.
  - clk_rise = clk_s & ~clk_s_d, where clk_s_d is a one-cycle delayed copy.
  - lat_rise is derived the same way from lat_s.
- LOAD state (lat_s = 1):
  - Every cycle: shift_reg <= ~buttons_eff; bit_count <= 0; nes_data <= ~buttons_eff[0].
  - clk_rise is ignored.
  - nes_data therefore tracks A with SYNC_STAGES+1 cycle latency from the latch pin.
- SHIFT state (lat_s = 0): on clk_rise:
  - If bit_count < 7: shift_reg <= {FILL_BIT, shift_reg[7:1]}; nes_data <= shift_reg[1]; bit_count++.
  - If bit_count == 7: shift as above, nes_data <= FILL_BIT, bit_count <= 8, frame_done <= 1 for one cycle.
  - If bit_count == 8: nes_data stays FILL_BIT; bit_count saturates; no frame_done.
- Without clk_rise, all state holds and frame_done = 0.
- Latency: host clock pin edge to nes_data change is SYNC_STAGES+1 clk cycles.
- Simultaneous events: a latch level high in the same cycle as clk_rise means latch wins (load, no shift).
- Latch reasserted mid-frame: bit_count returns to 0 immediately; the partial frame is abandoned without a frame_done pulse.
- Reset mid-frame: all outputs return to their reset values on the next clk edge.
- buttons is sampled only while lat_s = 1. Changes during SHIFT have no effect until the next latch.
- Host timing requirement: latch and clock high/low phases must each be at least SYNC_STAGES+2 clk cycles. Behaviour is undefined below this.

Optional Feature:
- Macro NES_TURBO_EN.
- When defined:
  - Port turbo_en[1:0] exists.
  - A TURBO_LOG2-bit counter increments on each lat_rise and wraps.
  - buttons_eff[0] = buttons[0] & (~turbo_en[0] | ctr[TURBO_LOG2-1]).
  - buttons_eff[1] = buttons[1] & (~turbo_en[1] | ctr[TURBO_LOG2-1]).
  - buttons_eff[7:2] = buttons[7:2].
  - With TURBO_LOG2=2, a held turbo A reads pressed on latches 2,3 of every 4 (counter values 2,3).
- When undefined: no turbo_en port, no counter, buttons_eff = buttons.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with buttons=8'hFF, latch=1 -> nes_data=1, bit_count=0, frame_done=0 throughout reset.
- Basic frame: buttons=8'b1000_0101 (Right,B... A=1,Select=1), latch pulse then 8 clocks of 4 cycles high / 4 cycles low -> nes_data sequence A..Right = 0,1,0,1,1,1,1,0; frame_done pulses once after the 8th edge; bit_count ends at 8.
- Over-clocking: 12 clocks after a latch with buttons=8'h00 -> bits 1-8 read 1; bits 9-12 read FILL_BIT=0; bit_count stays 8; exactly one frame_done.
- Mid-frame relatch: latch after 3 clocks with buttons changed to 8'h01 -> bit_count=0; nes_data=0 within SYNC_STAGES+1 cycles of latch; no frame_done from the aborted frame.
- Edge-case timing: nes_clk rising while latch is high -> no shift, bit_count stays 0. Buttons toggled during SHIFT -> output bits unaffected.
- Turbo (NES_TURBO_EN, TURBO_LOG2=2): buttons=8'h01, turbo_en=2'b01, 8 consecutive latch frames -> first bit reads 1,1,0,0,1,1,0,0. With turbo_en=0 -> first bit reads 0 in every frame.

Source files
------------

// File: rtl/nes_controller_responder.sv
// NES pad emulator: 4021-style parallel-in/serial-out responder driven by host latch/clock lines.
// Optional turbo on A/B buttons is built when NES_TURBO_EN is defined.
module nes_controller_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_BIT    = 1'b0
`ifdef NES_TURBO_EN
    , parameter int TURBO_LOG2  = 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons,
    input  logic       nes_latch,
    input  logic       nes_clk,
`ifdef NES_TURBO_EN
    input  logic [1:0] turbo_en,
`endif
    output logic       nes_data,
    output logic [3:0] bit_count,
    output logic       frame_done
);

    logic [SYNC_STAGES-1:0] lat_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   lat_s;
    logic                   clk_s;
    logic                   lat_s_d;
    logic                   clk_s_d;
    logic                   lat_rise;
    logic                   clk_rise;

    logic [7:0] shift_reg;
    logic [7:0] shift_nxt;
    logic       data_nxt;
    logic [3:0] count_nxt;
    logic       done_nxt;
    logic [7:0] buttons_eff;

    assign lat_s    = lat_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign lat_rise = lat_s & ~lat_s_d;
    assign clk_rise = clk_s & ~clk_s_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_sync <= '0;
            clk_sync <= '0;
            lat_s_d  <= 1'b0;
            clk_s_d  <= 1'b0;
        end else begin
            lat_sync <= {lat_sync[SYNC_STAGES-2:0], nes_latch};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], nes_clk};
            lat_s_d  <= lat_s;
            clk_s_d  <= clk_s;
        end
    end

`ifdef NES_TURBO_EN
    logic [TURBO_LOG2-1:0] turbo_ctr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turbo_ctr <= '0;
        end else if (lat_rise) begin
            turbo_ctr <= turbo_ctr + TURBO_LOG2'(1);
        end
    end

    always_comb begin
        buttons_eff    = buttons;
        buttons_eff[0] = buttons[0] & (~turbo_en[0] | turbo_ctr[TURBO_LOG2-1]);
        buttons_eff[1] = buttons[1] & (~turbo_en[1] | turbo_ctr[TURBO_LOG2-1]);
    end
`else
    logic unused_lat_rise;

    assign unused_lat_rise = lat_rise;
    assign buttons_eff     = buttons;
`endif

    // Latch level has priority over a coincident host clock edge.
    always_comb begin
        shift_nxt = shift_reg;
        data_nxt  = nes_data;
        count_nxt = bit_count;
        done_nxt  = 1'b0;
        if (lat_s) begin
            shift_nxt = ~buttons_eff;
            data_nxt  = ~buttons_eff[0];
            count_nxt = 4'd0;
        end else if (clk_rise && (bit_count < 4'd8)) begin
            shift_nxt = {FILL_BIT, shift_reg[7:1]};
            count_nxt = bit_count + 4'd1;
            if (bit_count == 4'd7) begin
                data_nxt = FILL_BIT;
                done_nxt = 1'b1;
            end else begin
                data_nxt = shift_reg[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg  <= 8'hFF;
            nes_data   <= 1'b1;
            bit_count  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            shift_reg  <= shift_nxt;
            nes_data   <= data_nxt;
            bit_count  <= count_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_nes_controller_responder.sv
// Randomized bench for nes_controller_responder against a frame-level model of the pad protocol.
// Build with +define+NES_TURBO_EN to also cover the turbo feature.
module tb_nes_controller_responder;

    localparam int   SYNC = 2;
    localparam logic FILL = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] buttons;
    logic       nes_latch;
    logic       nes_clk;
    logic       nes_data;
    logic [3:0] bit_count;
    logic       frame_done;
`ifdef NES_TURBO_EN
    logic [1:0] turbo_en;
`endif

    nes_controller_responder #(
        .SYNC_STAGES (SYNC),
        .FILL_BIT    (FILL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
`ifdef NES_TURBO_EN
        .turbo_en   (turbo_en),
`endif
        .nes_data   (nes_data),
        .bit_count  (bit_count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;

    // Model state: pressed-button snapshot of the current frame, host clocks seen since it, latch events since reset.
    logic [7:0] snap;
    int         nshift;
    int         lat_events;

    always @(negedge clk) if (rst_n === 1'b1 && frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int phase();
        return int'($urandom_range(7, SYNC + 2));
    endfunction

    function automatic logic exp_data();
        if (nshift < 8) return ~snap[nshift];
        return FILL;
    endfunction

    function automatic logic [3:0] exp_count();
        return (nshift > 8) ? 4'd8 : 4'(nshift);
    endfunction

    // Pressed set the pad should report for a latch with raw buttons b.
    function automatic logic [7:0] effective(input logic [7:0] b);
        logic [7:0] e;
        e = b;
`ifdef NES_TURBO_EN
        if ((lat_events % 4) < 2) begin
            if (turbo_en[0]) e[0] = 1'b0;
            if (turbo_en[1]) e[1] = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_data"}, {7'd0, nes_data}, {7'd0, exp_data()});
        chk({tag, "_cnt"}, {4'd0, bit_count}, {4'd0, exp_count()});
    endtask

    task automatic latch_pulse(input logic [7:0] b);
        buttons   = b;
        nes_latch = 1'b1;
        lat_events++;
        snap   = effective(b);
        nshift = 0;
        cyc(phase());
        check_state("latch_hi");
        nes_latch = 1'b0;
        cyc(phase());
        check_state("latch_lo");
    endtask

    task automatic clock_pulse();
        nes_clk = 1'b1;
        nshift++;
        cyc(phase());
        check_state("shift");
        buttons = 8'($urandom);
        nes_clk = 1'b0;
        cyc(phase());
    endtask

    task automatic frame(input logic [7:0] b, input int nclk);
        int fd0;
        fd0 = fd_cnt;
        latch_pulse(b);
        for (int i = 0; i < nclk; i++) clock_pulse();
        chk("frame_done_cnt", 8'(fd_cnt - fd0), (nclk >= 8) ? 8'd1 : 8'd0);
    endtask

    initial begin
        int fd0;
        rst_n      = 1'b0;
        buttons    = 8'hFF;
        nes_latch  = 1'b1;
        nes_clk    = 1'b0;
        lat_events = 0;
        nshift     = 8;
        snap       = 8'h00;
`ifdef NES_TURBO_EN
        turbo_en = 2'b00;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_data", {7'd0, nes_data}, 8'd1);
            chk("rst_cnt", {4'd0, bit_count}, 8'd0);
            chk("rst_done", {7'd0, frame_done}, 8'd0);
        end
        nes_latch = 1'b0;
        cyc(4);
        rst_n = 1'b1;
        cyc(4);

        frame(8'b1000_0101, 8);
        frame(8'h00, 12);

        // Relatch after 3 bits: partial frame abandoned, new buttons loaded.
        fd0 = fd_cnt;
        latch_pulse(8'($urandom));
        for (int i = 0; i < 3; i++) clock_pulse();
        buttons   = 8'h01;
        nes_latch = 1'b1;
        lat_events++;
        snap   = effective(8'h01);
        nshift = 0;
        cyc(SYNC + 1);
        check_state("relatch");
        cyc(2);
        nes_latch = 1'b0;
        cyc(phase());
        for (int i = 0; i < 8; i++) clock_pulse();
        chk("relatch_done_cnt", 8'(fd_cnt - fd0), 8'd1);

        // Host clock rising while latch is held: load wins, no shift.
        buttons   = 8'h5A;
        nes_latch = 1'b1;
        lat_events++;
        snap   = effective(8'h5A);
        nshift = 0;
        cyc(phase());
        nes_clk = 1'b1;
        cyc(phase());
        check_state("clk_in_latch");
        nes_clk = 1'b0;
        cyc(phase());
        nes_latch = 1'b0;
        cyc(phase());
        check_state("clk_in_latch_after");
        for (int i = 0; i < 8; i++) clock_pulse();

        for (int f = 0; f < 10; f++) frame(8'($urandom), int'($urandom_range(12, 0)));

`ifdef NES_TURBO_EN
        turbo_en = 2'b01;
        for (int f = 0; f < 8; f++) frame(8'h01, 1);
        turbo_en = 2'b11;
        for (int f = 0; f < 4; f++) frame(8'h03, 2);
        turbo_en = 2'b00;
        for (int f = 0; f < 4; f++) frame(8'h01, 1);
`endif

        // Reset mid-frame returns outputs to reset values.
        latch_pulse(8'h00);
        clock_pulse();
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_data", {7'd0, nes_data}, 8'd1);
        chk("midrst_cnt", {4'd0, bit_count}, 8'd0);
        chk("midrst_done", {7'd0, frame_done}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
